// File: rtl/timer_bank.sv
// Multi-channel programmable down-counting timer bank with a per-channel register window.
// Each channel has a reload value, a prescaler, one-shot/periodic modes, a tick pulse and a sticky pending flag.
module timer_bank #(
  parameter int NCH = 4,
  parameter int CW  = 16,
  parameter int DW  = 16,
  parameter int PW  = 8,
  parameter int AW  = $clog2(NCH) + 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           we,
  input  logic [AW-1:0]  addr,
  input  logic [DW-1:0]  wdata,
  output logic [DW-1:0]  rdata,
  output logic [NCH-1:0] tick,
  output logic [NCH-1:0] irq,
  output logic           irq_any
);

  logic [CW-1:0]  load_r  [NCH];
  logic [CW-1:0]  count_r [NCH];
  logic [PW-1:0]  pre_r   [NCH];
  logic [PW-1:0]  psc_r   [NCH];
  logic [NCH-1:0] en_r, per_r, ie_r, pending_r, tick_r;

  logic [AW-1:0]  ch_s;
  logic [1:0]     sel_s;
  logic [NCH-1:0] wr_load_s, wr_ctrl_s, wr_count_s, wr_stat_s;
  logic [NCH-1:0] step_s, term_s;
  logic [DW-1:0]  rd_ch_s [NCH];
  logic [DW-1:0]  rdata_s;
  logic           unused_wdata_s;

  // Not every wdata bit maps to a field for all parameter sets.
  assign unused_wdata_s = ^wdata;

  // Address decode, write strobes and prescale/terminal detection per channel.
  always_comb begin
    ch_s       = addr >> 2'd2;
    sel_s      = addr[1:0];
    wr_load_s  = '0;
    wr_ctrl_s  = '0;
    wr_count_s = '0;
    wr_stat_s  = '0;
    step_s     = '0;
    term_s     = '0;
    for (int i = 0; i < NCH; i++) begin
      wr_load_s[i]  = we && (ch_s == AW'(i)) && (sel_s == 2'd0);
      wr_ctrl_s[i]  = we && (ch_s == AW'(i)) && (sel_s == 2'd1);
      wr_count_s[i] = we && (ch_s == AW'(i)) && (sel_s == 2'd2);
      wr_stat_s[i]  = we && (ch_s == AW'(i)) && (sel_s == 2'd3);
      step_s[i]     = en_r[i] && (psc_r[i] == pre_r[i]);
      // A direct COUNT write discards the step landing on the same edge.
      term_s[i]     = step_s[i] && (count_r[i] == '0) && !wr_count_s[i];
    end
  end

  // Per-channel read views, then an AND-OR mux so out-of-range channels read 0.
  always_comb begin
    rdata_s = '0;
    for (int i = 0; i < NCH; i++) begin
      rd_ch_s[i] = '0;
      case (sel_s)
        2'd0: rd_ch_s[i][CW-1:0] = load_r[i];
        2'd1: begin
          rd_ch_s[i][0]      = en_r[i];
          rd_ch_s[i][1]      = per_r[i];
          rd_ch_s[i][2]      = ie_r[i];
          rd_ch_s[i][8 +: PW] = pre_r[i];
        end
        2'd2: rd_ch_s[i][CW-1:0] = count_r[i];
        2'd3: rd_ch_s[i][0] = pending_r[i];
        default: rd_ch_s[i] = '0;
      endcase
      rdata_s = rdata_s | (rd_ch_s[i] & {DW{ch_s == AW'(i)}});
    end
  end

  // Channel state: registers, prescaler, down-counter, tick and sticky pending.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        load_r[i]  <= '0;
        count_r[i] <= '0;
        pre_r[i]   <= '0;
        psc_r[i]   <= '0;
      end
      en_r      <= '0;
      per_r     <= '0;
      ie_r      <= '0;
      pending_r <= '0;
      tick_r    <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        tick_r[i] <= term_s[i];
        if (term_s[i]) begin
          pending_r[i] <= 1'b1;
        end else if (wr_stat_s[i] && wdata[0]) begin
          pending_r[i] <= 1'b0;
        end
        if (wr_load_s[i]) begin
          load_r[i] <= wdata[CW-1:0];
        end
        // A CTRL write overrides the one-shot auto-disable on the same edge.
        if (wr_ctrl_s[i]) begin
          en_r[i]  <= wdata[0];
          per_r[i] <= wdata[1];
          ie_r[i]  <= wdata[2];
          pre_r[i] <= wdata[8 +: PW];
        end else if (term_s[i] && !per_r[i]) begin
          en_r[i] <= 1'b0;
        end
        if (wr_count_s[i]) begin
          count_r[i] <= wdata[CW-1:0];
          psc_r[i]   <= '0;
        end else begin
          if (wr_ctrl_s[i]) begin
            psc_r[i] <= '0;
          end else if (en_r[i]) begin
            psc_r[i] <= step_s[i] ? '0 : psc_r[i] + PW'(1'b1);
          end
          if (wr_ctrl_s[i] && wdata[0] && !en_r[i]) begin
            count_r[i] <= load_r[i];
          end else if (step_s[i]) begin
            if (count_r[i] != '0) begin
              count_r[i] <= count_r[i] - CW'(1'b1);
            end else if (per_r[i]) begin
              count_r[i] <= load_r[i];
            end
          end
        end
      end
    end
  end

  assign rdata   = rdata_s;
  assign tick    = tick_r;
  assign irq     = pending_r & ie_r;
  assign irq_any = |irq;

endmodule

// File: doc/timer_bank.md
Name: timer_bank

Overview:
- Multi-channel programmable timer with memory-mapped register access; successor to the fixed single-channel terminal-count timer.
- Sits on the CPU I/O bus beside the transceiver.
- Each channel has a reload value, a prescaler, one-shot or periodic mode, a one-cycle tick output and a sticky interrupt-pending flag with software clear.

Parameters:
NCH, 4, number of independent timer channels (1..16)
CW, 16, counter/reload width in bits (1..DW)
DW, 16, CPU data bus width
PW, 8, prescaler field width (PW <= DW-8)
AW, $clog2(NCH)+2, address width (derived; not overridden)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
we  input  1  register write strobe, sampled on rising clk
addr  input  AW  addr[1:0] register select, addr[AW-1:2] channel index
wdata  input  DW  write data
rdata  output  DW  combinational read data for addr
tick  output  NCH  registered one-cycle pulse per channel on terminal count
irq  output  NCH  pending & ie per channel
irq_any  output  1  OR of irq

Behaviour:
- Register map per channel:
  - sel 0 LOAD: reload value, CW bits.
  - sel 1 CTRL: bit0 en, bit1 periodic, bit2 ie, bits[8+PW-1:8] PRE.
  - sel 2 COUNT: current counter value.
  - sel 3 STATUS: bit0 pending; writing 1 clears it, writing 0 has no effect.
- Width rules:
  - Reads are zero-extended to DW; unused bits read 0.
  - Writes are truncated to the field width.
  - A channel index >= NCH ignores writes and reads 0.
- Reset: LOAD, CTRL, COUNT, prescale counters, pending and tick are all 0. rdata, irq and irq_any are therefore 0 while reset is held. Reset mid-count aborts immediately, with no tick.
- Enable and reload:
  - A CTRL write with en going 0->1 loads COUNT <= LOAD and clears that channel's prescale counter.
  - A CTRL write keeping en=1 does not reload, but still clears the prescale counter.
  - Clearing en freezes COUNT and the prescale counter.
- Prescale: while en=1, the prescale counter increments each clk. When it equals PRE it wraps to 0 and issues a step, so a step occurs every PRE+1 cycles.
- On a step:
  - If COUNT != 0: COUNT <= COUNT-1.
  - If COUNT == 0 (terminal): tick <= 1 and pending <= 1.
    - Periodic: COUNT <= LOAD.
    - One-shot: en <= 0 and COUNT stays 0.
- Period is (LOAD+1)*(PRE+1) cycles. LOAD=0 with PRE=0 in periodic mode gives tick high every cycle.
- tick is high for exactly the cycle following each terminal edge; otherwise 0.
- LOAD writes while running take effect only at the next reload.
- A COUNT write loads COUNT directly and clears the prescale counter. It takes priority over a step on the same edge, and that step is discarded.
- A STATUS clear on the same edge as a terminal event: set wins, pending stays 1.
- A CTRL write on the same edge as a one-shot terminal: the written CTRL value wins. The tick and pending from that terminal still occur.
- irq[i] = pending[i] & ie[i], combinational. irq_any = |irq.
- Channels are fully independent; there are no cross-channel interactions.

Test Plan:
- Reset held during active counting → tick, irq, irq_any 0; all registers read 0; no tick after release until re-enabled.
- ch0 LOAD=3, CTRL=0x0007 (PRE=0) → tick on the cycle after the 4th edge following the write, then every 4 cycles; STATUS reads 1; irq[0]=1, irq_any=1.
- ch1 LOAD=2, CTRL=0x0105 (PRE=1, one-shot, ie) → single tick after 6 edges; CTRL reads 0x0104; COUNT reads 0; no further ticks over 50 cycles.
- ch0 periodic LOAD=0 PRE=0, write STATUS=1 every cycle → pending stays 1 (set beats clear); stop via CTRL=0, then STATUS=1 → pending 0, irq 0.
- ch2 running LOAD=100, write COUNT=5 mid-count → tick 6 step-periods later, then reload to 100; simultaneous ch3 with ie=0 → tick[3] pulses but irq[3]=0 and it does not contribute to irq_any.
- Write/read addr with channel index >= NCH (NCH=3) → rdata 0; no channel state changes; CW=8 with LOAD write 0x1FF → reads 0x00FF.
